// File: rtl/mem_access_unit.sv
// Memory access stage: MAR/MDR registers plus an IDLE/ACCESS/DONE sequencer that
// drives one read or write per request against a fixed-latency synchronous memory.
module mem_access_unit #(
  parameter int width       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [width-1:0] bus_in,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             req,
  input  logic             we,
  input  logic [width-1:0] mem_rdata,
  output logic [width-1:0] mar,
  output logic [width-1:0] mdr,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  output logic             mem_oe,
  output logic             mem_we,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             op_write_q, op_write_d;
  logic [width-1:0] mar_q, mar_d;
  logic [width-1:0] mdr_q, mdr_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      mar_q      <= '0;
      mdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    case (state_q)
      IDLE, DONE: begin
        // Loads land on the accepting edge, so a same-cycle request sees the new MAR/MDR.
        if (LD_MAR) mar_d = bus_in;
        if (LD_MDR) mdr_d = bus_in;
        if (req) begin
          state_d    = ACCESS;
          op_write_d = we;
          cnt_d      = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!op_write_q) mdr_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign busy      = (state_q == ACCESS);
  assign mem_oe    = busy && !op_write_q;
  assign mem_we    = busy && op_write_q;
  assign done      = (state_q == DONE);

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage for the 16-bit datapath. It holds the MAR and MDR registers, sequences one read or write per request against a fixed-latency synchronous memory, and presents MDR as the memory-side source of the shared data bus. It sits directly upstream of the bus selector, which gates `mdr` onto the bus. It also consumes the bus value when MAR or MDR is loaded from the datapath.

## Interface
- `width`, default 16: data and address width.
- `WAIT_CYCLES`, default 2: memory access cycles per transaction. Legal range is 1..15.

- `Clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `Reset`: input, 1 bit. Synchronous, active-high.
- `bus_in`: input, `width` bits. Current data bus value.
- `LD_MAR`: input, 1 bit. Load MAR from `bus_in`.
- `LD_MDR`: input, 1 bit. Load MDR from `bus_in`.
- `req`: input, 1 bit. Start a transaction; sampled only when the request is accepted (see Operation).
- `we`: input, 1 bit. Qualifies `req`: 1 selects write, 0 selects read.
- `mem_rdata`: input, `width` bits. Memory read data.
- `mar`: output, `width` bits. MAR register.
- `mdr`: output, `width` bits. MDR register; feeds the bus selector.
- `mem_addr`: output, `width` bits. Equals `mar` at all times.
- `mem_wdata`: output, `width` bits. Equals `mdr` at all times.
- `mem_oe`: output, 1 bit. Read strobe; high for every ACCESS cycle of a read.
- `mem_we`: output, 1 bit. Write strobe; high for every ACCESS cycle of a write.
- `busy`: output, 1 bit. High in ACCESS.
- `done`: output, 1 bit. Single-cycle completion pulse; high in DONE.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - `req`=1 goes to ACCESS, latching `we` into an internal `op_write` bit and loading the wait counter with `WAIT_CYCLES-1`.
  - Otherwise stays in IDLE.
- **ACCESS:**
  - `mem_oe` = !`op_write`; `mem_we` = `op_write`.
  - The counter decrements each cycle.
  - When the counter is 0, the next state is DONE. On a read, MDR captures `mem_rdata` at that same edge.
- **DONE:**
  - `done`=1 for exactly one cycle.
  - `req`=1 is accepted as in IDLE, which allows back-to-back transactions.
  - Otherwise goes to IDLE.
- **Request filtering:** `req` in ACCESS is ignored; it is neither queued nor extended.
- **MAR/MDR loads:**
  - `LD_MAR` and `LD_MDR` take effect in IDLE and DONE.
  - Both are ignored in ACCESS, so address and write data stay stable for the whole access.
- **Simultaneous load and request (IDLE or DONE):**
  - `LD_MAR` with `req` in the same cycle: MAR loads at the accepting edge, and the transaction uses the new address.
  - `LD_MDR` with a write `req`: the write uses the newly loaded value.
- **MDR write priority:** read capture (end of ACCESS) > `LD_MDR` (IDLE/DONE only). They never coincide.
- **Counter:** 4 bits, unsigned, no wrap; it is never decremented below 0.
- **Reset:**
  - Applies at the next edge from any state, including mid-ACCESS.
  - State goes to IDLE; MAR=0, MDR=0, counter=0, `op_write`=0.
  - An aborted read does not update MDR.

## Timing
- **Reset values:** `mar`=0, `mdr`=0, `mem_addr`=0, `mem_wdata`=0, `mem_oe`=0, `mem_we`=0, `busy`=0, `done`=0.
- **Request to completion:** with `req` sampled at edge E0:
  - ACCESS occupies cycles 1..W, where W = `WAIT_CYCLES`.
  - `done` is high in cycle W+1.
  - On a read, `mdr` shows the new data from cycle W+1 onward.
- **Strobes:** all outputs are registered or decode state only; there is no combinational path from inputs to outputs.
  - `mem_oe`/`mem_we` rise the cycle after the accepting edge.
  - They fall at the start of DONE.
- **Memory contract:** `mem_rdata` must be valid by the last ACCESS cycle.
- **Back-to-back:** `req` held high continuously gives one transaction every W+1 cycles.

## Test plan
- **Reset defaults:** assert `Reset` 2 cycles with random inputs → all outputs 0 and state IDLE.
- **Read, `WAIT_CYCLES`=2:**
  - Stimulus: `LD_MAR` with `bus_in`=16'h3000, then `req`=1, `we`=0; memory returns 16'hBEEF.
  - Response: `mem_oe` high for exactly 2 cycles with `mem_addr`=16'h3000; `done` in cycle 3; `mdr`=16'hBEEF.
- **Write with same-cycle load:**
  - Stimulus: `LD_MDR` with `bus_in`=16'h1234 in the same cycle as `req`=1, `we`=1 and MAR=16'h0042.
  - Response: `mem_we` high 2 cycles with `mem_wdata`=16'h1234 and `mem_addr`=16'h0042; `mdr` unchanged after `done`.
- **Loads and requests ignored in ACCESS:**
  - Stimulus: pulse `LD_MAR` (`bus_in`=16'hFFFF) and a second `req` during ACCESS.
  - Response: `mar` keeps its old value; exactly one `done` pulse.
- **Reset mid-access:**
  - Stimulus: assert `Reset` in the first ACCESS cycle of a read of 16'hBEEF.
  - Response: next cycle `mem_oe`=0, `busy`=0, `mdr`=0; no `done` pulse.
- **Back-to-back, `WAIT_CYCLES`=1:**
  - Stimulus: `req` held high for two reads at addresses 16'h0010 and 16'h0011, with `LD_MAR` in the DONE cycle.
  - Response: `done` pulses in cycles 2 and 4; second access uses 16'h0011.
